// File: rtl/flowstat_pkg.sv
// Shared definitions for the flowstat frame-statistics stage:
// register map, FSM state encoding and default widths.
package flowstat_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_COUNT_W = 24;
    localparam int DEF_SUM_W   = DEF_DATA_W + DEF_COUNT_W;

    localparam logic [3:0] REG_CTRL   = 4'd0;
    localparam logic [3:0] REG_STATUS = 4'd1;
    localparam logic [3:0] REG_MIN    = 4'd2;
    localparam logic [3:0] REG_MAX    = 4'd3;
    localparam logic [3:0] REG_COUNT  = 4'd4;
    localparam logic [3:0] REG_SUM_LO = 4'd5;
    localparam logic [3:0] REG_SUM_HI = 4'd6;
    localparam logic [3:0] REG_FRAMES = 4'd7;

    typedef enum logic [1:0] {
        ST_WAIT_LOW = 2'd0,
        ST_IDLE     = 2'd1,
        ST_ACC      = 2'd2
    } state_t;

endpackage

// File: rtl/flowstat_slave.sv
// Register-bus slave for flowstat: CTRL/STATUS, latched frame results
// and the registered read mux.
module flowstat_slave
    import flowstat_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int COUNT_W = DEF_COUNT_W,
    parameter int SUM_W   = DATA_W + COUNT_W
) (
    input  logic               clk_proc,
    input  logic               reset,
    input  logic [3:0]         addr_rel_i,
    input  logic               wr_i,
    input  logic [31:0]        datawr_i,
    input  logic               rd_i,
    output logic [31:0]        datard_o,
    input  logic               latch,
    input  logic [DATA_W-1:0]  acc_min,
    input  logic [DATA_W-1:0]  acc_max,
    input  logic [COUNT_W-1:0] acc_count,
    input  logic [SUM_W-1:0]   acc_sum,
    input  logic               acc_sat,
    output logic               enable
);

    logic               enable_r;
    logic               valid_r;
    logic               sat_r;
    logic [DATA_W-1:0]  min_r;
    logic [DATA_W-1:0]  max_r;
    logic [COUNT_W-1:0] count_r;
    logic [SUM_W-1:0]   sum_r;
    logic [31:0]        frames_r;
    logic [31:0]        datard_r;
    logic [31:0]        rd_mux_s;
    logic [63:0]        sum_ext_s;
    logic               ctrl_wr_s;
    logic               clear_s;

    assign ctrl_wr_s = wr_i && (addr_rel_i == REG_CTRL);
    assign clear_s   = ctrl_wr_s && datawr_i[1];
    assign sum_ext_s = 64'(sum_r);
    assign enable    = enable_r;
    assign datard_o  = datard_r;

    // Read mux over the current (pre-latch) register contents
    always_comb begin
        rd_mux_s = 32'd0;
        case (addr_rel_i)
            REG_CTRL:   rd_mux_s = {31'd0, enable_r};
            REG_STATUS: rd_mux_s = {30'd0, sat_r, valid_r};
            REG_MIN:    rd_mux_s = 32'(min_r);
            REG_MAX:    rd_mux_s = 32'(max_r);
            REG_COUNT:  rd_mux_s = 32'(count_r);
            REG_SUM_LO: rd_mux_s = sum_ext_s[31:0];
            REG_SUM_HI: rd_mux_s = {24'd0, sum_ext_s[39:32]};
            REG_FRAMES: rd_mux_s = frames_r;
            default:    rd_mux_s = 32'd0;
        endcase
    end

    // Control, result registers and read data; clear beats a same-cycle latch
    always_ff @(posedge clk_proc) begin
        if (reset) begin
            enable_r <= 1'b1;
            valid_r  <= 1'b0;
            sat_r    <= 1'b0;
            min_r    <= '0;
            max_r    <= '0;
            count_r  <= '0;
            sum_r    <= '0;
            frames_r <= 32'd0;
            datard_r <= 32'd0;
        end else begin
            if (ctrl_wr_s) begin
                enable_r <= datawr_i[0];
            end
            if (clear_s) begin
                valid_r  <= 1'b0;
                sat_r    <= 1'b0;
                min_r    <= '0;
                max_r    <= '0;
                count_r  <= '0;
                sum_r    <= '0;
                frames_r <= 32'd0;
            end else if (latch && enable_r) begin
                valid_r  <= 1'b1;
                sat_r    <= acc_sat;
                min_r    <= acc_min;
                max_r    <= acc_max;
                count_r  <= acc_count;
                sum_r    <= acc_sum;
                frames_r <= frames_r + 32'd1;
            end
            if (rd_i) begin
                datard_r <= rd_mux_s;
            end
        end
    end

endmodule

// File: rtl/flowstat.sv
// Frame-statistics stage: 1-cycle pixel pass-through plus per-frame
// min/max/count/sum accumulation latched at frame end.
module flowstat
    import flowstat_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int COUNT_W = DEF_COUNT_W,
    parameter int SUM_W   = DATA_W + COUNT_W
) (
    input  logic              clk_proc,
    input  logic              reset,
    input  logic              in_fv,
    input  logic              in_dv,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_fv,
    output logic              out_dv,
    output logic [DATA_W-1:0] out_data,
    input  logic [3:0]        addr_rel_i,
    input  logic              wr_i,
    input  logic [31:0]       datawr_i,
    input  logic              rd_i,
    output logic [31:0]       datard_o
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    state_t             state_r, state_s;
    logic [DATA_W-1:0]  min_r, min_s, max_r, max_s;
    logic [COUNT_W-1:0] cnt_r, cnt_s;
    logic [SUM_W-1:0]   sum_r, sum_s;
    logic               sat_r, sat_s;
    logic               latch_s;
    logic               enable_s;

    // Pass-through register stage, independent of statistics state
    always_ff @(posedge clk_proc) begin
        if (reset) begin
            out_fv   <= 1'b0;
            out_dv   <= 1'b0;
            out_data <= '0;
        end else begin
            out_fv   <= in_fv;
            out_dv   <= in_dv;
            out_data <= in_data;
        end
    end

    // Next-state and accumulator update; frame end raises latch_s
    always_comb begin
        state_s = state_r;
        min_s   = min_r;
        max_s   = max_r;
        cnt_s   = cnt_r;
        sum_s   = sum_r;
        sat_s   = sat_r;
        latch_s = 1'b0;
        case (state_r)
            ST_WAIT_LOW: begin
                if (!in_fv) state_s = ST_IDLE;
                else        state_s = ST_WAIT_LOW;
            end
            ST_IDLE: begin
                if (in_fv) begin
                    state_s = ST_ACC;
                    sat_s   = 1'b0;
                    if (in_dv) begin
                        min_s = in_data;
                        max_s = in_data;
                        cnt_s = COUNT_W'(1);
                        sum_s = SUM_W'(in_data);
                    end else begin
                        min_s = '1;
                        max_s = '0;
                        cnt_s = '0;
                        sum_s = '0;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (!in_fv) begin
                    state_s = ST_IDLE;
                    latch_s = 1'b1;
                end else if (in_dv) begin
                    if (in_data < min_r) min_s = in_data;
                    else                 min_s = min_r;
                    if (in_data > max_r) max_s = in_data;
                    else                 max_s = max_r;
                    // Once the count is pinned, the sum freezes too so it never wraps
                    if (cnt_r == CNT_MAX) begin
                        sat_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + COUNT_W'(1);
                        sum_s = sum_r + SUM_W'(in_data);
                    end
                end else begin
                    state_s = ST_ACC;
                end
            end
            default: state_s = ST_WAIT_LOW;
        endcase
    end

    // FSM state and accumulator registers
    always_ff @(posedge clk_proc) begin
        if (reset) begin
            state_r <= ST_WAIT_LOW;
            min_r   <= '1;
            max_r   <= '0;
            cnt_r   <= '0;
            sum_r   <= '0;
            sat_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            min_r   <= min_s;
            max_r   <= max_s;
            cnt_r   <= cnt_s;
            sum_r   <= sum_s;
            sat_r   <= sat_s;
        end
    end

    flowstat_slave #(
        .DATA_W  (DATA_W),
        .COUNT_W (COUNT_W),
        .SUM_W   (SUM_W)
    ) u_slave (
        .clk_proc   (clk_proc),
        .reset      (reset),
        .addr_rel_i (addr_rel_i),
        .wr_i       (wr_i),
        .datawr_i   (datawr_i),
        .rd_i       (rd_i),
        .datard_o   (datard_o),
        .latch      (latch_s),
        .acc_min    (min_r),
        .acc_max    (max_r),
        .acc_count  (cnt_r),
        .acc_sum    (sum_r),
        .acc_sat    (sat_r),
        .enable     (enable_s)
    );

endmodule

// File: tb/tb_flowstat.sv
// Self-checking bench for flowstat: pass-through scoreboard plus
// table-driven register readback after each frame scenario.
`timescale 1ns/1ps
module tb_flowstat;
    import flowstat_pkg::*;

    logic        clk_proc = 1'b0;
    logic        reset;
    logic        in_fv, in_dv;
    logic [15:0] in_data;
    logic [3:0]  addr_rel_i;
    logic        wr_i, rd_i;
    logic [31:0] datawr_i;
    logic        out_fv_a, out_dv_a, out_fv_b, out_dv_b;
    logic [15:0] out_data_a, out_data_b;
    logic [31:0] datard_a, datard_b;

    int errors = 0;
    int checks = 0;

    logic [17:0] exp_q[$];
    logic [15:0] pix_q[$];

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    always #5 clk_proc = ~clk_proc;

    flowstat dut_a (
        .clk_proc(clk_proc), .reset(reset),
        .in_fv(in_fv), .in_dv(in_dv), .in_data(in_data),
        .out_fv(out_fv_a), .out_dv(out_dv_a), .out_data(out_data_a),
        .addr_rel_i(addr_rel_i), .wr_i(wr_i), .datawr_i(datawr_i),
        .rd_i(rd_i), .datard_o(datard_a)
    );

    flowstat #(.COUNT_W(4)) dut_b (
        .clk_proc(clk_proc), .reset(reset),
        .in_fv(in_fv), .in_dv(in_dv), .in_data(in_data),
        .out_fv(out_fv_b), .out_dv(out_dv_b), .out_data(out_data_b),
        .addr_rel_i(addr_rel_i), .wr_i(wr_i), .datawr_i(datawr_i),
        .rd_i(rd_i), .datard_o(datard_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected pass-through is captured as the DUT samples its inputs
    always @(posedge clk_proc) begin
        exp_q.push_back(reset ? 18'd0 : {in_fv, in_dv, in_data});
    end

    // Compare forwarded flow on the falling edge
    always @(negedge clk_proc) begin
        logic [17:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("passthru_a", {46'd0, out_fv_a, out_dv_a, out_data_a}, {46'd0, e});
            chk("passthru_b", {46'd0, out_fv_b, out_dv_b, out_data_b}, {46'd0, e});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic fv, input logic dv, input logic [15:0] d);
        in_fv = fv; in_dv = dv; in_data = d;
        @(posedge clk_proc); #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        addr_rel_i = a; datawr_i = d; wr_i = 1'b1;
        @(posedge clk_proc); #1;
        wr_i = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a);
        addr_rel_i = a; rd_i = 1'b1;
        @(posedge clk_proc); #1;
        rd_i = 1'b0;
    endtask

    // Frame from pix_q with random dv gaps, then one fv-low cycle that may carry a clear or read
    task automatic run_frame(input bit clr_end, input bit rd_end,
                             input logic [3:0] rd_addr, input logic [31:0] rd_exp);
        foreach (pix_q[i]) begin
            repeat ($urandom_range(0, 2)) drive(1'b1, 1'b0, 16'($urandom));
            drive(1'b1, 1'b1, pix_q[i]);
        end
        in_fv = 1'b0; in_dv = 1'b0;
        if (clr_end) begin addr_rel_i = REG_CTRL; datawr_i = 32'd3; wr_i = 1'b1; end
        if (rd_end)  begin addr_rel_i = rd_addr;  rd_i = 1'b1; end
        @(posedge clk_proc); #1;
        wr_i = 1'b0; rd_i = 1'b0;
        if (rd_end) chk("pre_latch_read", {32'd0, datard_a}, {32'd0, rd_exp});
    endtask

    task automatic check_results(input string tag, input logic [31:0] mn, input logic [31:0] mx,
                                 input logic [31:0] cnt, input logic [63:0] sum,
                                 input logic [31:0] frames, input logic [31:0] status);
        vec_t v[7];
        v[0] = '{REG_MIN,    mn,                    "MIN"};
        v[1] = '{REG_MAX,    mx,                    "MAX"};
        v[2] = '{REG_COUNT,  cnt,                   "COUNT"};
        v[3] = '{REG_SUM_LO, sum[31:0],             "SUM_LO"};
        v[4] = '{REG_SUM_HI, {24'd0, sum[39:32]},   "SUM_HI"};
        v[5] = '{REG_FRAMES, frames,                "FRAMES"};
        v[6] = '{REG_STATUS, status,                "STATUS"};
        for (int i = 0; i < 7; i++) begin
            do_read(v[i].addr);
            chk({tag, "_", v[i].name}, {32'd0, datard_a}, {32'd0, v[i].exp});
        end
    endtask

    initial begin
        reset = 1'b1; in_fv = 1'b0; in_dv = 1'b0; in_data = 16'd0;
        addr_rel_i = 4'd0; wr_i = 1'b0; rd_i = 1'b0; datawr_i = 32'd0;
        drive(1'b1, 1'b1, 16'hABCD);
        drive(1'b0, 1'b0, 16'd0);
        drive(1'b0, 1'b0, 16'd0);
        chk("reset_datard", {32'd0, datard_a}, 64'd0);
        chk("reset_out", {46'd0, out_fv_a, out_dv_a, out_data_a}, 64'd0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 16'd0);
        do_read(REG_CTRL);
        chk("reset_ctrl", {32'd0, datard_a}, 64'd1);
        check_results("reset", 32'd0, 32'd0, 32'd0, 64'd0, 32'd0, 32'd0);

        // dv without fv must be ignored
        drive(1'b0, 1'b1, 16'd1);
        drive(1'b0, 1'b1, 16'd2);
        pix_q = '{16'd100, 16'd7, 16'd65535, 16'd300};
        run_frame(1'b0, 1'b0, 4'd0, 32'd0);
        check_results("basic", 32'd7, 32'd65535, 32'd4, 64'd65942, 32'd1, 32'd1);

        // Reset mid-frame; release with fv still high
        drive(1'b1, 1'b1, 16'd50);
        drive(1'b1, 1'b1, 16'd60);
        reset = 1'b1;
        drive(1'b1, 1'b1, 16'd70);
        drive(1'b1, 1'b0, 16'd0);
        reset = 1'b0;
        drive(1'b1, 1'b1, 16'd80);
        drive(1'b1, 1'b1, 16'd90);
        drive(1'b0, 1'b0, 16'd0);
        check_results("cut", 32'd0, 32'd0, 32'd0, 64'd0, 32'd0, 32'd0);
        pix_q = '{16'd10, 16'd20, 16'd30};
        run_frame(1'b0, 1'b0, 4'd0, 32'd0);
        check_results("after_cut", 32'd10, 32'd30, 32'd3, 64'd60, 32'd1, 32'd1);

        // Empty frame, with a read of FRAMES on the latch cycle
        drive(1'b1, 1'b0, 16'd0);
        drive(1'b1, 1'b0, 16'd0);
        pix_q = {};
        run_frame(1'b0, 1'b1, REG_FRAMES, 32'd1);
        check_results("empty", 32'h0000FFFF, 32'd0, 32'd0, 64'd0, 32'd2, 32'd1);

        // Disabled frame is dropped
        do_write(REG_CTRL, 32'd0);
        do_read(REG_CTRL);
        chk("ctrl_off", {32'd0, datard_a}, 64'd0);
        pix_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        run_frame(1'b0, 1'b0, 4'd0, 32'd0);
        check_results("disabled", 32'h0000FFFF, 32'd0, 32'd0, 64'd0, 32'd2, 32'd1);
        do_write(REG_CTRL, 32'd1);
        run_frame(1'b0, 1'b0, 4'd0, 32'd0);
        check_results("reenabled", 32'd1, 32'd5, 32'd5, 64'd15, 32'd3, 32'd1);

        // Clear on the frame-end cycle wins over the latch
        pix_q = '{16'd9, 16'd8};
        run_frame(1'b1, 1'b0, 4'd0, 32'd0);
        check_results("clear", 32'd0, 32'd0, 32'd0, 64'd0, 32'd0, 32'd0);
        do_read(REG_CTRL);
        chk("ctrl_after_clear", {32'd0, datard_a}, 64'd1);
        pix_q = '{16'd40000, 16'd50000};
        run_frame(1'b0, 1'b0, 4'd0, 32'd0);
        check_results("post_clear", 32'd40000, 32'd50000, 32'd2, 64'd90000, 32'd1, 32'd1);

        // Saturation on the narrow-counter instance
        do_write(REG_CTRL, 32'd3);
        pix_q = {};
        for (int i = 0; i < 20; i++) pix_q.push_back(16'd1);
        run_frame(1'b0, 1'b0, 4'd0, 32'd0);
        check_results("wide20", 32'd1, 32'd1, 32'd20, 64'd20, 32'd1, 32'd1);
        do_read(REG_COUNT);
        chk("sat_count", {32'd0, datard_b}, 64'd15);
        do_read(REG_SUM_LO);
        chk("sat_sum", {32'd0, datard_b}, 64'd15);
        do_read(REG_STATUS);
        chk("sat_status", {32'd0, datard_b}, 64'd3);
        do_read(REG_FRAMES);
        chk("sat_frames", {32'd0, datard_b}, 64'd1);

        // Back-to-back frames with a single fv-low cycle between them
        pix_q = '{16'd5, 16'd6};
        run_frame(1'b0, 1'b0, 4'd0, 32'd0);
        pix_q = '{16'd1000};
        run_frame(1'b0, 1'b1, REG_FRAMES, 32'd2);
        check_results("b2b", 32'd1000, 32'd1000, 32'd1, 64'd1000, 32'd3, 32'd1);
        do_read(REG_STATUS);
        chk("b2b_status_b", {32'd0, datard_b}, 64'd1);

        do_read(4'd9);
        chk("unmapped", {32'd0, datard_a}, 64'd0);

        drive(1'b0, 1'b0, 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flowstat.md
# flowstat

Frame-statistics stage placed directly downstream of `normhw` on the 16-bit pixel flow. It forwards the flow unchanged with one register stage. It accumulates per-frame min, max, pixel count and pixel sum, and latches them at each frame end. Results are exposed on the standard slave register bus for software readback of normalization quality.

## Interface
- `DATA_W`, 16, pixel width of `in_data`/`out_data`
- `COUNT_W`, 24, pixel counter width (saturating)
- `SUM_W`, 40, sum accumulator width (= `DATA_W`+`COUNT_W`)
- `clk_proc`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_fv`  in  1  frame valid
- `in_dv`  in  1  data valid; meaningful only while `in_fv`=1
- `in_data`  in  `DATA_W`  pixel
- `out_fv`  out  1  registered `in_fv`
- `out_dv`  out  1  registered `in_dv`
- `out_data`  out  `DATA_W`  registered `in_data`
- `addr_rel_i`  in  4  register word address
- `wr_i`  in  1  write strobe, one cycle
- `datawr_i`  in  32  write data
- `rd_i`  in  1  read strobe, one cycle
- `datard_o`  out  32  read data

## Operation
- Pass-through is always active and unaffected by enable, clear or state.
- Register map (32-bit, unused bits read 0, unmapped addresses read 0):
  - 0 CTRL: bit0 `enable` (reset 1, R/W); bit1 `clear` (write 1 pulses, reads 0).
  - 1 STATUS (RO): bit0 `valid`, bit1 `sat`.
  - 2 MIN, 3 MAX, 4 COUNT, 5 SUM[31:0], 6 SUM[39:32].
  - 7 FRAMES: 32-bit frame counter, wraps.
- FSM:
  - `WAIT_LOW` (reset state): stays until `in_fv`=0, then goes to `IDLE`. This prevents counting a frame that was cut by reset.
  - `IDLE`: when `in_fv`=1, goes to `ACC` and initialises accumulators to min=all-ones, max=0, count=0, sum=0, `sat_acc`=0. If `in_dv`=1 in that same cycle, the pixel is counted as the first sample.
  - `ACC`: each `in_fv`&`in_dv` cycle updates min, max, count+1 and sum+data. When `in_fv`=0, goes to `IDLE` and performs the frame-end latch.
- Frame-end latch, only when `enable`=1:
  - Copies accumulators to the result registers.
  - Sets `valid`, sets `sat`:=`sat_acc`, and increments FRAMES.
  - With `enable`=0 the frame is dropped and results hold.
- Saturation: count stops at 2^`COUNT_W`−1 and sets `sat_acc`. Sum stops updating once count has saturated. Sum therefore never wraps.
- Empty frame (fv pulse with no dv) latches min=0xFFFF, max=0, count=0, sum=0.
- `in_dv`=1 while `in_fv`=0 is ignored and is still forwarded.
- `clear` zeroes MIN, MAX, COUNT, SUM, FRAMES, `valid` and `sat`. It does not touch the in-progress accumulators.
- Clear in the same cycle as a frame-end latch: clear wins; the frame is not latched or counted.

## Timing
- Pass-through latency is exactly 1 cycle.
- Reset values:
  - `out_fv`, `out_dv`, `out_data` = 0.
  - `datard_o` = 0.
  - All result registers = 0, `valid`=0, `sat`=0, `enable`=1, FSM=`WAIT_LOW`.
- Frame-end latch happens on the edge at which `in_fv`=0 is sampled. Results are readable from the following cycle.
- Write takes effect on the edge sampling `wr_i`.
- `datard_o` is registered: it is valid 1 cycle after `rd_i` and holds until the next read.
- A read in the same cycle as a latch returns the pre-latch value.
- Back-to-back frames with one fv-low cycle between them are fully supported.

## Structure
- Package `flowstat_pkg` holds:
  - register address constants (`REG_CTRL`…`REG_FRAMES`);
  - the FSM state enum;
  - the `COUNT_W`/`SUM_W` defaults.
- Sub-module `flowstat_slave` holds the bus decode, CTRL/STATUS registers and the registered read mux. The top level holds the pass-through, FSM and accumulators.

## Test plan
- Reset, then a frame with pixels 100, 7, 65535, 300 and random dv gaps, then fv low. Required: MIN=7, MAX=65535, COUNT=4, SUM=65942, FRAMES=1, `valid`=1. Out flow equals in flow delayed 1 cycle.
- Assert reset mid-frame, then release with `in_fv` still high. Required: that frame is not latched and FRAMES=0. The next full frame latches correctly.
- Frame with no dv. Required: MIN=0xFFFF, MAX=0, COUNT=0, SUM=0, FRAMES increments.
- Write CTRL=0, run a frame of 5 pixels. Required: results unchanged and FRAMES unchanged. Write CTRL=1, rerun. Required: COUNT=5.
- Pulse `clear` on the exact cycle fv falls. Required: all results 0, FRAMES=0, `valid`=0. The next frame latches normally.
- Run with `COUNT_W`=4 and a frame of 20 pixels of value 1. Required: COUNT=15, SUM=15, `sat`=1.
